seq_pattern_detector: RTL and testbench

- Serial bit-stream pattern detector built as a Moore finite state machine.
- Samples one input bit per clock and asserts a one-cycle flag when the most recent bits equal a programmable pattern.
- Default pattern is 1001, with overlapping matches allowed.
- Sits between a serial data source and control logic that consumes the match pulse.

---
 rtl/seq_pattern_detector_pkg.sv | 68 ++++++
 rtl/seq_pattern_detector_next_state.sv | 30 +++
 rtl/seq_pattern_detector.sv | 53 +++++
 tb/tb_seq_pattern_detector.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/seq_pattern_detector_pkg.sv
// Shared definitions for the serial pattern detector: state encoding helpers
// and the elaboration-time KMP next-state computation.
package seq_pattern_detector_pkg;

    // Longest supported pattern and the index widths needed to address it
    localparam int MAX_LEN    = 16;
    localparam int PAT_IDX_W  = 4;
    localparam int HIST_IDX_W = 5;

    // S0 (empty prefix) is always encoded as zero
    localparam int S0_CODE = 0;

    // Binary state register width: S0..S(PAT_LEN-1) plus SD
    function automatic int state_width(input int pat_len);
        return $clog2(pat_len + 1);
    endfunction

    // SD sits directly after the last prefix state
    function automatic int sd_code(input int pat_len);
        return pat_len;
    endfunction

    // Next state for (state, x). Prefix state k means the last k bits equal the
    // first k pattern bits, so the received history is rebuilt from the
    // pattern itself followed by x. The result is the longest pattern prefix
    // that is a suffix of that history (KMP failure function). SD is treated
    // as a full-length prefix when overlapping, and as a fresh start otherwise.
    // Encodings above SD are unreachable and fall back to S0.
    function automatic int calc_next(
        input int                 state,
        input logic               x,
        input logic [MAX_LEN-1:0] pattern,
        input int                 pat_len,
        input bit                 overlap
    );
        logic [MAX_LEN:0] hist;
        int               len;
        int               best;
        bit               ok;

        if (state > pat_len)
            return S0_CODE;

        if (state == pat_len && !overlap)
            return (x == pattern[PAT_IDX_W'(pat_len - 1)]) ? 1 : S0_CODE;

        hist = '0;
        for (int i = 0; i < MAX_LEN; i++)
            if (i < state)
                hist[HIST_IDX_W'(i)] = pattern[PAT_IDX_W'(pat_len - 1 - i)];
        hist[HIST_IDX_W'(state)] = x;
        len = state + 1;

        best = S0_CODE;
        for (int l = 1; l <= MAX_LEN; l++) begin
            if (l <= len && l <= pat_len) begin
                ok = 1'b1;
                for (int j = 0; j < MAX_LEN; j++)
                    if (j < l && hist[HIST_IDX_W'(len - l + j)] != pattern[PAT_IDX_W'(pat_len - 1 - j)])
                        ok = 1'b0;
                if (ok)
                    best = l;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_pattern_detector_next_state.sv
// Combinational next-state logic: a lookup table indexed by {state, x} whose
// contents are computed entirely at elaboration from the pattern parameters.
module seq_next_state
    import seq_pattern_detector_pkg::*;
#(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1001,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 STATE_W = 3
) (
    input  logic [STATE_W-1:0] state,
    input  logic               x,
    output logic [STATE_W-1:0] next
);

    localparam int NUM = 1 << STATE_W;

    logic [STATE_W-1:0] lut [2*NUM];

    // One table entry per (state, x) pair, including unreachable encodings
    for (genvar i = 0; i < 2*NUM; i++) begin : g_lut
        localparam int   S  = i / 2;
        localparam logic XB = 1'(i % 2);
        assign lut[i] = STATE_W'(calc_next(S, XB, MAX_LEN'(PATTERN), PAT_LEN, OVERLAP));
    end

    // Select the successor for the current state and incoming bit
    assign next = lut[{state, x}];

endmodule

// File: rtl/seq_pattern_detector.sv
// Moore serial pattern detector: y pulses for one cycle after the last bit
// of PATTERN (MSB first) has been sampled.
module seq_pattern_detector
    import seq_pattern_detector_pkg::*;
#(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1001,
    parameter bit                 OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic x,
    output logic y
);

    localparam int STATE_W = state_width(PAT_LEN);

    if (PAT_LEN < 2 || PAT_LEN > MAX_LEN) begin : g_bad_len
        $error("seq_pattern_detector: PAT_LEN out of range 2..16");
    end

    // Only the two architecturally special states are named; prefix states
    // Sk are encoded as the binary value k in between.
    typedef enum logic [STATE_W-1:0] {
        S0 = STATE_W'(S0_CODE),
        SD = STATE_W'(sd_code(PAT_LEN))
    } state_e;

    state_e             state;
    logic [STATE_W-1:0] next;

    seq_next_state #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN),
        .OVERLAP (OVERLAP),
        .STATE_W (STATE_W)
    ) u_next (
        .state (state),
        .x     (x),
        .next  (next)
    );

    // State register; reset drops any partial match immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S0;
        else
            state <= state_e'(next);
    end

    assign y = (state == SD);

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed, table-driven bench for seq_pattern_detector with pattern 1001,
// run side by side in overlapping and non-overlapping configurations.
module tb_seq_pattern_detector;

    logic clk;
    logic rst;
    logic x;
    logic y_ovl;
    logic y_nov;

    int checks;
    int errors;

    typedef struct {
        logic rst;
        logic x;
        logic y_ovl;
        logic y_nov;
    } vec_t;

    vec_t vecs[$];

    seq_pattern_detector #(
        .PAT_LEN (4),
        .PATTERN (4'b1001),
        .OVERLAP (1'b1)
    ) dut_ovl (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .y   (y_ovl)
    );

    seq_pattern_detector #(
        .PAT_LEN (4),
        .PATTERN (4'b1001),
        .OVERLAP (1'b0)
    ) dut_nov (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .y   (y_nov)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: y=%0b expected %0b", name, actual, expected);
        end
    endtask

    // Drive one bit on the falling edge, then check both outputs just after
    // the rising edge that samples it
    task automatic apply_stimulus(input string name, input logic r, input logic b,
                                  input logic e_ovl, input logic e_nov);
        @(negedge clk);
        rst = r;
        x   = b;
        @(posedge clk);
        #1;
        check_output({name, "/ovl"}, y_ovl, e_ovl);
        check_output({name, "/nov"}, y_nov, e_nov);
    endtask

    task automatic push(input logic r, input logic b, input logic e_ovl, input logic e_nov);
        vec_t v;
        v.rst   = r;
        v.x     = b;
        v.y_ovl = e_ovl;
        v.y_nov = e_nov;
        vecs.push_back(v);
    endtask

    task automatic push_bits(input logic [31:0] bits, input int n,
                             input logic [31:0] m_ovl, input logic [31:0] m_nov);
        for (int i = 0; i < n; i++)
            push(1'b0, bits[n-1-i], m_ovl[n-1-i], m_nov[n-1-i]);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        x      = 1'b0;

        // Table: each entry is one sampled bit and the y expected after it
        // Bits seen right after reset: 0,0,1 must not pair with x=1 held in reset
        push_bits(32'b001, 3, 32'b000, 32'b000);
        push(1'b1, 1'b1, 1'b0, 1'b0);
        // Main stream 1,0,1,1,0,0,1,0,0,1,0,0
        push_bits(32'b101100100100, 12, 32'b000000100100, 32'b000000100000);
        push(1'b1, 1'b0, 1'b0, 1'b0);
        // Mismatch recovery 1,1,0,0,1
        push_bits(32'b11001, 5, 32'b00001, 32'b00001);
        push(1'b1, 1'b0, 1'b0, 1'b0);
        // Chained overlapping matches 1,0,0,1,0,0,1,0,0,1
        push_bits(32'b1001001001, 10, 32'b0001001001, 32'b0001000001);
        push(1'b1, 1'b0, 1'b0, 1'b0);
        // Long runs: 20 zeros then 20 ones
        push_bits(32'h0, 20, 32'h0, 32'h0);
        push_bits(32'hFFFFF, 20, 32'h0, 32'h0);
        push(1'b1, 1'b0, 1'b0, 1'b0);

        // Reset held with x=1 toggling the clock: y stays low
        #1;
        check_output("reset_t0/ovl", y_ovl, 1'b0);
        check_output("reset_t0/nov", y_nov, 1'b0);
        apply_stimulus("reset_hold0", 1'b1, 1'b1, 1'b0, 1'b0);
        apply_stimulus("reset_hold1", 1'b1, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++)
            apply_stimulus($sformatf("vec%0d", i), vecs[i].rst, vecs[i].x,
                           vecs[i].y_ovl, vecs[i].y_nov);

        // Reset asserted while y is high drops y without a clock edge
        apply_stimulus("pre_hi0", 1'b0, 1'b1, 1'b0, 1'b0);
        apply_stimulus("pre_hi1", 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus("pre_hi2", 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus("pre_hi3", 1'b0, 1'b1, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_output("async_drop/ovl", y_ovl, 1'b0);
        check_output("async_drop/nov", y_nov, 1'b0);

        // Partial 1,0,0 then a reset pulse between edges discards history
        apply_stimulus("mid0", 1'b0, 1'b1, 1'b0, 1'b0);
        apply_stimulus("mid1", 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus("mid2", 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        apply_stimulus("mid_after_rst", 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        apply_stimulus("post0", 1'b0, 1'b1, 1'b0, 1'b0);
        apply_stimulus("post1", 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus("post2", 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus("post3", 1'b0, 1'b1, 1'b1, 1'b1);
        apply_stimulus("post4", 1'b0, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
